// File: rtl/cmos_capture_ctrl.sv
// rtl/cmos_capture_ctrl.sv - CMOS sensor capture front end with frame gating and geometry measurement
//
// Registers and delays the sensor vsync/href/data bus by DLY pixel_clk cycles,
// reduces RAW_WIDTH samples to DATA_WIDTH (truncate or round-half-up with
// saturation), passes only whole frames after SKIP_FRAMES start-up frames and
// measures lines per frame / pixels per line of each captured frame.
//
// Optional build macro: CMOS_CAPTURE_TESTPAT_EN adds a testpat input that,
// when sampled high at frame_start, replaces data_out with a horizontal ramp.
//
// Ports:
//   pixel_clk    - sensor pixel clock, sole clock
//   rst_n        - asynchronous active-low reset
//   enable       - capture enable
//   vsync        - sensor frame sync, active level set by VSYNC_POL
//   href         - sensor line valid
//   data_in      - sensor pixel, RAW_WIDTH bits
//   testpat      - (CMOS_CAPTURE_TESTPAT_EN only) ramp select, sampled at frame_start
//   vsync_out    - delayed, gated, active-high vsync
//   href_out     - delayed, gated href
//   data_out     - reduced pixel, 0 when href_out is low
//   frame_start  - one-cycle pulse on the first captured vsync_out cycle
//   frame_done   - one-cycle pulse when a captured frame ends
//   lines_o      - line count of the last completed captured frame
//   ppl_o        - pixels in line 0 of the last completed captured frame
//   line_len_err - sticky per frame, some line length differed from line 0
module cmos_capture_ctrl #(
    parameter int RAW_WIDTH   = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int DLY         = 2,
    parameter int VSYNC_POL   = 1,
    parameter int SKIP_FRAMES = 2,
    parameter int ROUND_MODE  = 0,
    parameter int CNT_WIDTH   = 12
) (
    input  logic                  pixel_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [RAW_WIDTH-1:0]  data_in,
`ifdef CMOS_CAPTURE_TESTPAT_EN
    input  logic                  testpat,
`endif
    output logic                  vsync_out,
    output logic                  href_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  lines_o,
    output logic [CNT_WIDTH-1:0]  ppl_o,
    output logic                  line_len_err
);

    localparam int S   = RAW_WIDTH - DATA_WIDTH;
    localparam int SKW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, CAPTURE} state_t;

    state_t         state_q, state_d;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;

    // Index 1 is the stage-1 register, index DLY drives the outputs.
    logic [DLY:1]                vs_q, vs_d;
    logic [DLY:1]                href_q, href_d;
    logic [DLY:1][RAW_WIDTH-1:0] data_q, data_d;
    // Side-band bits are born at stage 1 (combinationally) and land in stage 2.
    logic [DLY:2]                gate_q, gate_d;
    logic [DLY:2]                fs_q, fs_d;
    logic [DLY:2]                fd_q, fd_d;

    logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_WIDTH-1:0] ref_len_q, ref_len_d;
    logic [CNT_WIDTH-1:0] lines_q, lines_d;
    logic [CNT_WIDTH-1:0] ppl_q, ppl_d;
    logic                 err_q, err_d;

    logic vs_rise, href_fall;
    logic gate_now, fs_now, fd_now;
    logic [DATA_WIDTH-1:0] red, pix_val;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign vs_rise   = vs_q[1] & ~vs_q[2];
    assign href_fall = ~href_q[1] & href_q[2];

    // FSM: state register
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            skip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && !vs_q[1]) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    if (SKIP_FRAMES > 0) begin
                        state_d    = SKIP;
                        skip_cnt_d = '0;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            SKIP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    if (skip_cnt_q == SKIP_LAST) state_d = CAPTURE;
                    else skip_cnt_d = skip_cnt_q + SKW'(1);
                end
            end
            default: begin
                // A running frame always completes; enable is only looked at on its closing edge.
                if (vs_rise && !enable) state_d = IDLE;
            end
        endcase
    end

    // FSM: outputs, attached to the stage-1 sample
    always_comb begin
        gate_now = (state_d == CAPTURE);
        fs_now   = vs_rise && (state_d == CAPTURE);
        fd_now   = vs_rise && (state_q == CAPTURE);
    end

    // Pipeline and side-band shift
    always_comb begin
        vs_d   = {vs_q[DLY-1:1], (VSYNC_POL != 0) ? vsync : ~vsync};
        href_d = {href_q[DLY-1:1], href};
        data_d = {data_q[DLY-1:1], data_in};
        gate_d = gate_q;
        fs_d   = fs_q;
        fd_d   = fd_q;
        gate_d[2] = gate_now;
        fs_d[2]   = fs_now;
        fd_d[2]   = fd_now;
        for (int k = 3; k <= DLY; k++) begin
            gate_d[k] = gate_q[k-1];
            fs_d[k]   = fs_q[k-1];
            fd_d[k]   = fd_q[k-1];
        end
    end

    // Frame geometry counters
    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        ref_len_d  = ref_len_q;
        err_d      = err_q;
        lines_d    = lines_q;
        ppl_d      = ppl_q;
        if (state_q == CAPTURE) begin
            if (href_q[1]) pix_cnt_d = sat_inc(pix_cnt_q);
            if (href_fall) begin
                line_cnt_d = sat_inc(line_cnt_q);
                if (line_cnt_q == '0) ref_len_d = pix_cnt_q;
                else if (pix_cnt_q != ref_len_q) err_d = 1'b1;
                pix_cnt_d = '0;
            end
            if (vs_rise) begin
                // A line ending on the same cycle as the frame is still counted.
                lines_d    = href_fall ? sat_inc(line_cnt_q) : line_cnt_q;
                ppl_d      = (href_fall && line_cnt_q == '0) ? pix_cnt_q : ref_len_q;
                pix_cnt_d  = '0;
                line_cnt_d = '0;
                ref_len_d  = '0;
                err_d      = 1'b0;
            end
        end else begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            ref_len_d  = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= '0;
            href_q     <= '0;
            data_q     <= '0;
            gate_q     <= '0;
            fs_q       <= '0;
            fd_q       <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            ref_len_q  <= '0;
            err_q      <= 1'b0;
            lines_q    <= '0;
            ppl_q      <= '0;
        end else begin
            vs_q       <= vs_d;
            href_q     <= href_d;
            data_q     <= data_d;
            gate_q     <= gate_d;
            fs_q       <= fs_d;
            fd_q       <= fd_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            ref_len_q  <= ref_len_d;
            err_q      <= err_d;
            lines_q    <= lines_d;
            ppl_q      <= ppl_d;
        end
    end

    // Width reduction on the final stage
    generate
        if (S > 0 && ROUND_MODE == 0) begin : g_trunc
            assign red = DATA_WIDTH'(data_q[DLY] >> S);
        end else if (S > 0) begin : g_round
            localparam logic [RAW_WIDTH:0] HALF = (RAW_WIDTH + 1)'(1) << (S - 1);
            logic [RAW_WIDTH:0] sum;
            assign sum = {1'b0, data_q[DLY]} + HALF;
            // The carry out of the raw width is the only way the result can exceed DATA_WIDTH.
            assign red = sum[RAW_WIDTH] ? '1 : DATA_WIDTH'(sum >> S);
        end else begin : g_widen
            assign red = DATA_WIDTH'(data_q[DLY]) << (DATA_WIDTH - RAW_WIDTH);
        end
    endgenerate

`ifdef CMOS_CAPTURE_TESTPAT_EN
    logic                         tp_q, tp_d, tp_now;
    logic [DLY:2]                 tpv_q, tpv_d;
    logic [DLY:2][DATA_WIDTH-1:0] ramp_q, ramp_d;

    always_comb begin
        tp_now    = fs_now ? testpat : tp_q;
        tp_d      = tp_now;
        tpv_d     = tpv_q;
        ramp_d    = ramp_q;
        tpv_d[2]  = tp_now;
        // pix_cnt before its increment is the index of the current pixel in the line.
        ramp_d[2] = DATA_WIDTH'(pix_cnt_q);
        for (int k = 3; k <= DLY; k++) begin
            tpv_d[k]  = tpv_q[k-1];
            ramp_d[k] = ramp_q[k-1];
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q   <= 1'b0;
            tpv_q  <= '0;
            ramp_q <= '0;
        end else begin
            tp_q   <= tp_d;
            tpv_q  <= tpv_d;
            ramp_q <= ramp_d;
        end
    end

    assign pix_val = tpv_q[DLY] ? ramp_q[DLY] : red;
`else
    assign pix_val = red;
`endif

    assign vsync_out    = vs_q[DLY] & gate_q[DLY];
    assign href_out     = href_q[DLY] & gate_q[DLY];
    assign data_out     = href_out ? pix_val : '0;
    assign frame_start  = fs_q[DLY];
    assign frame_done   = fd_q[DLY];
    assign lines_o      = lines_q;
    assign ppl_o        = ppl_q;
    assign line_len_err = err_q;

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// tb/tb_cmos_capture_ctrl.sv - self-checking bench for cmos_capture_ctrl
module tb_cmos_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [9:0] data_in = '0;
    logic       vsync_b;

    // Instance a: DLY 2, rounding, two skipped frames, active-high vsync.
    logic        vsync_out_a, href_out_a, frame_start_a, frame_done_a, err_a;
    logic [7:0]  data_out_a;
    logic [11:0] lines_a, ppl_a;
    // Instance b: DLY 4, truncation, no skip, active-low vsync fed the inverted strobe.
    logic        vsync_out_b, href_out_b, frame_start_b, frame_done_b, err_b;
    logic [7:0]  data_out_b;
    logic [11:0] lines_b, ppl_b;

    assign vsync_b = ~vsync;

    cmos_capture_ctrl #(.DLY(2), .SKIP_FRAMES(2), .ROUND_MODE(1), .VSYNC_POL(1)) dut_a (
        .pixel_clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync), .href(href),
        .data_in(data_in), .vsync_out(vsync_out_a), .href_out(href_out_a),
        .data_out(data_out_a), .frame_start(frame_start_a), .frame_done(frame_done_a),
        .lines_o(lines_a), .ppl_o(ppl_a), .line_len_err(err_a));

    cmos_capture_ctrl #(.DLY(4), .SKIP_FRAMES(0), .ROUND_MODE(0), .VSYNC_POL(0)) dut_b (
        .pixel_clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync_b), .href(href),
        .data_in(data_in), .vsync_out(vsync_out_b), .href_out(href_out_b),
        .data_out(data_out_b), .frame_start(frame_start_b), .frame_done(frame_done_b),
        .lines_o(lines_b), .ppl_o(ppl_b), .line_len_err(err_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] raw;
        logic [7:0] rnd;
        logic [7:0] trn;
    } vec_t;
    vec_t tbl[8];

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } px_t;
    typedef struct {
        logic [11:0] lines;
        logic [11:0] ppl;
    } geo_t;

    px_t  sb_a[$], sb_b[$];
    geo_t gq_a[$], gq_b[$];
    px_t  pe_a, pe_b;
    geo_t ge_a, ge_b;

    int checks = 0, errors = 0;
    int fs_a = 0, fd_a = 0, fs_b = 0, fd_b = 0;
    int exp_fs_a = 0, exp_fd_a = 0, exp_fs_b = 0, exp_fd_b = 0;
    bit open_a = 0, open_b = 0;
    int cur_lines = 0, cur_ppl = 0;
    int pk = 0;
    logic pvs_a = 1'b0, pvs_b = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (href_out_a) begin
                chk("a_href_expected", sb_a.size() != 0, 1);
                if (sb_a.size() != 0) begin
                    pe_a = sb_a.pop_front();
                    chk("a_px_cycle", cyc, pe_a.cyc);
                    chk("a_px_data", data_out_a, pe_a.d);
                end
            end
            if (frame_start_a) begin
                fs_a++;
                chk("a_fs_align", {pvs_a, vsync_out_a}, 2'b01);
            end
            if (frame_done_a) begin
                fd_a++;
                chk("a_fd_expected", gq_a.size() != 0, 1);
                if (gq_a.size() != 0) begin
                    ge_a = gq_a.pop_front();
                    chk("a_lines", lines_a, ge_a.lines);
                    chk("a_ppl", ppl_a, ge_a.ppl);
                end
            end
        end
        pvs_a = vsync_out_a;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (href_out_b) begin
                chk("b_href_expected", sb_b.size() != 0, 1);
                if (sb_b.size() != 0) begin
                    pe_b = sb_b.pop_front();
                    chk("b_px_cycle", cyc, pe_b.cyc);
                    chk("b_px_data", data_out_b, pe_b.d);
                end
            end
            if (frame_start_b) begin
                fs_b++;
                chk("b_fs_align", {pvs_b, vsync_out_b}, 2'b01);
            end
            if (frame_done_b) begin
                fd_b++;
                chk("b_fd_expected", gq_b.size() != 0, 1);
                if (gq_b.size() != 0) begin
                    ge_b = gq_b.pop_front();
                    chk("b_lines", lines_b, ge_b.lines);
                    chk("b_ppl", ppl_b, ge_b.ppl);
                end
            end
        end
        pvs_b = vsync_out_b;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_px();
        href    = 1'b1;
        data_in = tbl[pk % 8].raw;
        if (open_a) sb_a.push_back('{cyc + 2, tbl[pk % 8].rnd});
        if (open_b) sb_b.push_back('{cyc + 4, tbl[pk % 8].trn});
        pk++;
        step();
        href = 1'b0;
    endtask

    // One frame: vsync pulse (closing the previous frame), then n lines.
    // ca/cb say whether instance a/b is expected to capture this frame.
    task automatic frame(input int n, input int l0, input int l1, input int l2,
                         input bit ca, input bit cb, input bit drop);
        int lens[3];
        lens[0] = l0;
        lens[1] = l1;
        lens[2] = l2;
        if (open_a) begin
            gq_a.push_back('{12'(cur_lines), 12'(cur_ppl)});
            exp_fd_a++;
        end
        if (open_b) begin
            gq_b.push_back('{12'(cur_lines), 12'(cur_ppl)});
            exp_fd_b++;
        end
        if (ca) exp_fs_a++;
        if (cb) exp_fs_b++;
        open_a    = ca;
        open_b    = cb;
        cur_lines = n;
        cur_ppl   = (n > 0) ? l0 : 0;
        vsync = 1'b1;
        idle(2);
        vsync = 1'b0;
        idle(2);
        for (int i = 0; i < n; i++) begin
            if (drop && i == 1) enable = 1'b0;
            for (int p = 0; p < lens[i]; p++) drive_px();
            idle(2);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_reset_a"}, {vsync_out_a, href_out_a, data_out_a, frame_start_a,
                                frame_done_a, lines_a, ppl_a, err_a}, 0);
        chk({tag, "_reset_b"}, {vsync_out_b, href_out_b, data_out_b, frame_start_b,
                                frame_done_b, lines_b, ppl_b, err_b}, 0);
    endtask

    initial begin
        tbl[0] = '{10'h3FF, 8'hFF, 8'hFF};
        tbl[1] = '{10'h201, 8'h80, 8'h80};
        tbl[2] = '{10'h104, 8'h41, 8'h41};
        tbl[3] = '{10'h002, 8'h01, 8'h00};
        tbl[4] = '{10'h001, 8'h00, 8'h00};
        tbl[5] = '{10'h3FD, 8'hFF, 8'hFF};
        tbl[6] = '{10'h3FE, 8'hFF, 8'hFF};
        tbl[7] = '{10'h006, 8'h02, 8'h01};

        idle(3);
        chk_reset_outputs("init");
        rst_n = 1'b1;
        idle(2);

        enable = 1'b1;
        idle(4);
        frame(3, 5, 5, 5, 0, 1, 0);
        frame(3, 5, 5, 5, 0, 1, 0);
        frame(3, 5, 5, 5, 1, 1, 0);
        frame(3, 5, 5, 5, 1, 1, 0);
        frame(3, 5, 5, 4, 1, 1, 0);
        chk("a_len_err_set", err_a, 1'b1);
        chk("b_len_err_set", err_b, 1'b1);
        frame(3, 5, 5, 5, 1, 1, 0);
        chk("a_len_err_clear", err_a, 1'b0);
        chk("b_len_err_clear", err_b, 1'b0);

        // enable drops in the middle of a captured frame; the frame still completes
        frame(3, 5, 5, 5, 1, 1, 1);
        frame(3, 5, 5, 5, 0, 0, 0);

        enable = 1'b1;
        idle(4);
        frame(3, 5, 5, 5, 0, 1, 0);

        // reset in the middle of a line
        frame(0, 0, 0, 0, 0, 1, 0);
        drive_px();
        drive_px();
        href    = 1'b1;
        data_in = 10'h3FF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midline");
        href = 1'b0;
        sb_a.delete();
        sb_b.delete();
        gq_a.delete();
        gq_b.delete();
        open_a = 0;
        open_b = 0;
        idle(3);
        rst_n = 1'b1;
        idle(4);

        frame(3, 5, 5, 5, 0, 1, 0);
        frame(3, 5, 5, 5, 0, 1, 0);
        frame(3, 5, 5, 5, 1, 1, 0);
        frame(3, 4, 4, 4, 1, 1, 0);
        enable = 1'b0;
        frame(0, 0, 0, 0, 0, 0, 0);
        idle(10);

        chk("a_frame_start_count", fs_a, exp_fs_a);
        chk("a_frame_done_count", fd_a, exp_fd_a);
        chk("b_frame_start_count", fs_b, exp_fs_b);
        chk("b_frame_done_count", fd_b, exp_fd_b);
        chk("a_px_drained", sb_a.size(), 0);
        chk("b_px_drained", sb_b.size(), 0);
        chk("a_geo_drained", gq_a.size(), 0);
        chk("b_geo_drained", gq_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
